// File: rtl/pim_tile_scheduler.sv
// pim_tile_scheduler
//   Sequences a pool of PIM units over a TILES_PER_DIM x TILES_PER_DIM tiled
//   matrix product. Tile jobs are issued row-major to free units in
//   round-robin order, completions are queued per unit and written back to
//   the aggregator one per cycle (lowest unit index first), and a one-cycle
//   done pulse marks the end of the whole matrix job.
//
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin a full matrix job (sampled only while idle)
//   unit_done   : per-unit one-cycle completion pulse
//   disp_valid  : one-hot dispatch pulse to the selected unit
//   disp_row/col: tile of the dispatched job
//   wb_valid    : writeback strobe to the aggregator
//   wb_unit/row/col : unit and tile of the written-back result
//   busy        : high while a matrix job is in progress
//   done        : one-cycle pulse after the last writeback
//   jobs_done   : writebacks since the last accepted start
module pim_tile_scheduler #(
    parameter int NUM_UNITS     = 4,
    parameter int TILES_PER_DIM = 2,
    localparam int IDX_W  = (TILES_PER_DIM > 1) ? $clog2(TILES_PER_DIM) : 1,
    localparam int UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    localparam int CNT_W  = $clog2(TILES_PER_DIM * TILES_PER_DIM + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic [NUM_UNITS-1:0] disp_valid,
    output logic [IDX_W-1:0]     disp_row,
    output logic [IDX_W-1:0]     disp_col,
    output logic                 wb_valid,
    output logic [UNIT_W-1:0]    wb_unit,
    output logic [IDX_W-1:0]     wb_row,
    output logic [IDX_W-1:0]     wb_col,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     jobs_done
);

    localparam int                TOTAL    = TILES_PER_DIM * TILES_PER_DIM;
    localparam logic [CNT_W-1:0]  TOTAL_C  = CNT_W'(TOTAL);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(TILES_PER_DIM - 1);
    localparam logic [UNIT_W-1:0] LAST_U   = UNIT_W'(NUM_UNITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t state, state_n;

    // Per-unit bookkeeping
    logic [NUM_UNITS-1:0] unit_busy, unit_busy_n;
    logic [NUM_UNITS-1:0] unit_pend, unit_pend_n;
    logic [IDX_W-1:0]     tile_row [NUM_UNITS];
    logic [IDX_W-1:0]     tile_col [NUM_UNITS];
    logic [IDX_W-1:0]     tile_row_n [NUM_UNITS];
    logic [IDX_W-1:0]     tile_col_n [NUM_UNITS];

    // Job sequencing
    logic [UNIT_W-1:0] rr_ptr, rr_ptr_n;
    logic [IDX_W-1:0]  next_row, next_row_n;
    logic [IDX_W-1:0]  next_col, next_col_n;
    logic [CNT_W-1:0]  disp_cnt, disp_cnt_n;

    // Next values of the registered outputs
    logic [NUM_UNITS-1:0] disp_valid_n;
    logic [IDX_W-1:0]     disp_row_n, disp_col_n;
    logic                 wb_valid_n;
    logic [UNIT_W-1:0]    wb_unit_n;
    logic [IDX_W-1:0]     wb_row_n, wb_col_n;
    logic                 busy_n, done_n;
    logic [CNT_W-1:0]     jobs_done_n;

    // Accepting a start dispatches in the same edge, so the dispatch search
    // runs on an "effective" view where an accepted start already looks like
    // a freshly cleared pool at tile (0,0) with the pointer at unit 0.
    logic                 accept;
    logic [NUM_UNITS-1:0] eff_busy, eff_pend, eff_free;
    logic [UNIT_W-1:0]    eff_ptr;
    logic [IDX_W-1:0]     eff_row, eff_col;
    logic [CNT_W-1:0]     eff_cnt;

    logic                 disp_hit, can_dispatch;
    logic [UNIT_W-1:0]    disp_sel;
    logic                 wb_hit;
    logic [UNIT_W-1:0]    wb_sel;

    always_comb begin : effective_view
        accept   = (state == S_IDLE) && start;
        eff_busy = accept ? '0 : unit_busy;
        eff_pend = accept ? '0 : unit_pend;
        eff_ptr  = accept ? '0 : rr_ptr;
        eff_row  = accept ? '0 : next_row;
        eff_col  = accept ? '0 : next_col;
        eff_cnt  = accept ? '0 : disp_cnt;
        eff_free = ~(eff_busy | eff_pend);
    end

    // Round-robin search as two priority passes: units at or above the
    // pointer first, then the wrap-around from unit 0.
    always_comb begin : pick_units
        disp_hit = 1'b0;
        disp_sel = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (!disp_hit && eff_free[i] && (UNIT_W'(i) >= eff_ptr)) begin
                disp_hit = 1'b1;
                disp_sel = UNIT_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (!disp_hit && eff_free[i]) begin
                disp_hit = 1'b1;
                disp_sel = UNIT_W'(i);
            end
        end
        wb_hit = 1'b0;
        wb_sel = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (!wb_hit && unit_pend[i]) begin
                wb_hit = 1'b1;
                wb_sel = UNIT_W'(i);
            end
        end
        can_dispatch = (accept || (state == S_RUN)) && disp_hit && (eff_cnt < TOTAL_C);
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start) state_n = S_RUN;
            S_RUN:    if (jobs_done == TOTAL_C) state_n = S_FINISH;
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // FSM: output / datapath next-value logic
    always_comb begin
        unit_busy_n  = eff_busy;
        unit_pend_n  = eff_pend;
        tile_row_n   = tile_row;
        tile_col_n   = tile_col;
        rr_ptr_n     = eff_ptr;
        next_row_n   = eff_row;
        next_col_n   = eff_col;
        disp_cnt_n   = eff_cnt;
        jobs_done_n  = accept ? '0 : jobs_done;
        disp_valid_n = '0;
        disp_row_n   = disp_row;
        disp_col_n   = disp_col;
        wb_valid_n   = 1'b0;
        wb_unit_n    = wb_unit;
        wb_row_n     = wb_row;
        wb_col_n     = wb_col;
        busy_n       = (state_n != S_IDLE);
        done_n       = (state_n == S_FINISH);

        if (state == S_RUN) begin
            // Completions on non-busy units are dropped by the mask.
            unit_busy_n = unit_busy & ~unit_done;
            unit_pend_n = unit_pend | (unit_done & unit_busy);
            if (wb_hit) begin
                unit_pend_n[wb_sel] = 1'b0;
                wb_valid_n          = 1'b1;
                wb_unit_n           = wb_sel;
                wb_row_n            = tile_row[wb_sel];
                wb_col_n            = tile_col[wb_sel];
                jobs_done_n         = jobs_done + 1'b1;
            end
        end

        // Dispatch uses free bits from the registered state, so a unit whose
        // pend clears this edge cannot be picked until the next one.
        if (can_dispatch) begin
            unit_busy_n[disp_sel]  = 1'b1;
            tile_row_n[disp_sel]   = eff_row;
            tile_col_n[disp_sel]   = eff_col;
            disp_valid_n[disp_sel] = 1'b1;
            disp_row_n             = eff_row;
            disp_col_n             = eff_col;
            disp_cnt_n             = eff_cnt + 1'b1;
            rr_ptr_n               = (disp_sel == LAST_U) ? '0 : disp_sel + 1'b1;
            if (eff_col == LAST_IDX) begin
                next_col_n = '0;
                next_row_n = eff_row + 1'b1;
            end else begin
                next_col_n = eff_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            unit_busy  <= '0;
            unit_pend  <= '0;
            for (int unsigned i = 0; i < NUM_UNITS; i++) begin
                tile_row[i] <= '0;
                tile_col[i] <= '0;
            end
            rr_ptr     <= '0;
            next_row   <= '0;
            next_col   <= '0;
            disp_cnt   <= '0;
            disp_valid <= '0;
            disp_row   <= '0;
            disp_col   <= '0;
            wb_valid   <= 1'b0;
            wb_unit    <= '0;
            wb_row     <= '0;
            wb_col     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            jobs_done  <= '0;
        end else begin
            unit_busy  <= unit_busy_n;
            unit_pend  <= unit_pend_n;
            tile_row   <= tile_row_n;
            tile_col   <= tile_col_n;
            rr_ptr     <= rr_ptr_n;
            next_row   <= next_row_n;
            next_col   <= next_col_n;
            disp_cnt   <= disp_cnt_n;
            disp_valid <= disp_valid_n;
            disp_row   <= disp_row_n;
            disp_col   <= disp_col_n;
            wb_valid   <= wb_valid_n;
            wb_unit    <= wb_unit_n;
            wb_row     <= wb_row_n;
            wb_col     <= wb_col_n;
            busy       <= busy_n;
            done       <= done_n;
            jobs_done  <= jobs_done_n;
        end
    end

endmodule

// File: tb/tb_pim_tile_scheduler.sv
module tb_pim_tile_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start;
    logic [7:0] ud;
    int         sel;

    // Instance A: 4 units, 2x2 tiles
    logic [3:0] a_dv, a_ud; logic [0:0] a_dr, a_dc, a_wr, a_wc; logic [1:0] a_wu;
    logic a_wv, a_busy, a_done, a_start; logic [2:0] a_jobs;
    // Instance B: 2 units, 3x3 tiles
    logic [1:0] b_dv, b_ud; logic [1:0] b_dr, b_dc, b_wr, b_wc; logic [0:0] b_wu;
    logic b_wv, b_busy, b_done, b_start; logic [3:0] b_jobs;
    // Instance C: 4 units, 1x1 tile
    logic [3:0] c_dv, c_ud; logic [0:0] c_dr, c_dc, c_wr, c_wc; logic [1:0] c_wu;
    logic c_wv, c_busy, c_done, c_start; logic [0:0] c_jobs;

    assign a_start = start && (sel == 0);
    assign b_start = start && (sel == 1);
    assign c_start = start && (sel == 2);
    assign a_ud    = (sel == 0) ? ud[3:0] : '0;
    assign b_ud    = (sel == 1) ? ud[1:0] : '0;
    assign c_ud    = (sel == 2) ? ud[3:0] : '0;

    pim_tile_scheduler #(.NUM_UNITS(4), .TILES_PER_DIM(2)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .unit_done(a_ud),
        .disp_valid(a_dv), .disp_row(a_dr), .disp_col(a_dc),
        .wb_valid(a_wv), .wb_unit(a_wu), .wb_row(a_wr), .wb_col(a_wc),
        .busy(a_busy), .done(a_done), .jobs_done(a_jobs));

    pim_tile_scheduler #(.NUM_UNITS(2), .TILES_PER_DIM(3)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .unit_done(b_ud),
        .disp_valid(b_dv), .disp_row(b_dr), .disp_col(b_dc),
        .wb_valid(b_wv), .wb_unit(b_wu), .wb_row(b_wr), .wb_col(b_wc),
        .busy(b_busy), .done(b_done), .jobs_done(b_jobs));

    pim_tile_scheduler #(.NUM_UNITS(4), .TILES_PER_DIM(1)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .unit_done(c_ud),
        .disp_valid(c_dv), .disp_row(c_dr), .disp_col(c_dc),
        .wb_valid(c_wv), .wb_unit(c_wu), .wb_row(c_wr), .wb_col(c_wc),
        .busy(c_busy), .done(c_done), .jobs_done(c_jobs));

    // Outputs of the selected instance, zero-extended to a common width
    logic [7:0] o_dv, o_dr, o_dc, o_wu, o_wr, o_wc, o_jobs;
    logic       o_wv, o_busy, o_done;

    always_comb begin
        o_dv = '0; o_dr = '0; o_dc = '0; o_wu = '0; o_wr = '0; o_wc = '0; o_jobs = '0;
        o_wv = 1'b0; o_busy = 1'b0; o_done = 1'b0;
        case (sel)
            0: begin
                o_dv = 8'(a_dv); o_dr = 8'(a_dr); o_dc = 8'(a_dc); o_wu = 8'(a_wu);
                o_wr = 8'(a_wr); o_wc = 8'(a_wc); o_jobs = 8'(a_jobs);
                o_wv = a_wv; o_busy = a_busy; o_done = a_done;
            end
            1: begin
                o_dv = 8'(b_dv); o_dr = 8'(b_dr); o_dc = 8'(b_dc); o_wu = 8'(b_wu);
                o_wr = 8'(b_wr); o_wc = 8'(b_wc); o_jobs = 8'(b_jobs);
                o_wv = b_wv; o_busy = b_busy; o_done = b_done;
            end
            default: begin
                o_dv = 8'(c_dv); o_dr = 8'(c_dr); o_dc = 8'(c_dc); o_wu = 8'(c_wu);
                o_wr = 8'(c_wr); o_wc = 8'(c_wc); o_jobs = 8'(c_jobs);
                o_wv = c_wv; o_busy = c_busy; o_done = c_done;
            end
        endcase
    end

    // Reference model: phase 0 idle / 1 running / 2 finishing; unit status
    // 0 free, 1 working, 2 result waiting; jobs numbered row-major.
    int nu, nt, total, phase, ptr, k, jobs, cyc;
    int st[8], tile_k[8], disp_cyc[8];
    int e_dv, e_dr, e_dc, e_wv, e_wu, e_wr, e_wc, e_busy, e_done, e_jobs;
    int tests = 0, failed = 0, done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, expv, cyc);
        end
    endtask

    task automatic set_cfg(input int s, input int u, input int t);
        sel = s; nu = u; nt = t; total = t * t;
        phase = 0; ptr = 0; k = 0; jobs = 0;
        for (int i = 0; i < 8; i++) begin st[i] = 0; tile_k[i] = 0; disp_cyc[i] = 0; end
        e_dv = 0; e_wv = 0; e_busy = 0; e_done = 0; e_jobs = 0;
    endtask

    task automatic model_dispatch(input int u);
        st[u] = 1; tile_k[u] = k; disp_cyc[u] = cyc;
        e_dv = 1 << u; e_dr = k / nt; e_dc = k % nt;
        k++; ptr = (u + 1) % nu;
    endtask

    task automatic model_step();
        int wbu, du, idx;
        e_dv = 0; e_wv = 0; e_done = 0;
        if (rst) begin
            phase = 0; ptr = 0; k = 0; jobs = 0;
            for (int i = 0; i < 8; i++) st[i] = 0;
        end else begin
            case (phase)
                0: if (start) begin
                    for (int i = 0; i < 8; i++) st[i] = 0;
                    k = 0; jobs = 0; ptr = 0;
                    model_dispatch(0);
                    phase = 1;
                end
                1: if (jobs == total) begin
                    phase = 2; e_done = 1;
                end else begin
                    wbu = -1; du = -1;
                    for (int i = 0; i < nu; i++) if (wbu < 0 && st[i] == 2) wbu = i;
                    if (k < total)
                        for (int j = 0; j < nu; j++) begin
                            idx = (ptr + j) % nu;
                            if (du < 0 && st[idx] == 0) du = idx;
                        end
                    for (int i = 0; i < nu; i++) if (ud[i] && st[i] == 1) st[i] = 2;
                    if (wbu >= 0) begin
                        e_wv = 1; e_wu = wbu;
                        e_wr = tile_k[wbu] / nt; e_wc = tile_k[wbu] % nt;
                        st[wbu] = 0; jobs++;
                    end
                    if (du >= 0) model_dispatch(du);
                end
                default: phase = 0;
            endcase
        end
        e_busy = (phase != 0) ? 1 : 0;
        e_jobs = jobs;
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        chk("disp_valid", 32'(o_dv), e_dv);
        if (e_dv != 0) begin
            chk("disp_row", 32'(o_dr), e_dr);
            chk("disp_col", 32'(o_dc), e_dc);
        end
        chk("wb_valid", 32'(o_wv), e_wv);
        if (e_wv != 0) begin
            chk("wb_unit", 32'(o_wu), e_wu);
            chk("wb_row", 32'(o_wr), e_wr);
            chk("wb_col", 32'(o_wc), e_wc);
        end
        chk("busy", 32'(o_busy), e_busy);
        chk("done", 32'(o_done), e_done);
        chk("jobs_done", 32'(o_jobs), e_jobs);
        if (o_done === 1'b1) done_seen++;
    endtask

    // Unit responder. mode 0: random latency; 1: fixed 5-cycle latency;
    // 2: all busy units complete together; 3: completions in dispatch order.
    task automatic drive(input int mode, input bit noise);
        int nb, first;
        ud = '0; start = 1'b0;
        case (mode)
            0: for (int i = 0; i < nu; i++) begin
                if (st[i] == 1 && $urandom_range(0, 2) == 0) ud[i] = 1'b1;
                else if (noise && st[i] != 1 && $urandom_range(0, 7) == 0) ud[i] = 1'b1;
            end
            1: for (int i = 0; i < nu; i++)
                if (st[i] == 1 && cyc + 1 == disp_cyc[i] + 5) ud[i] = 1'b1;
            2: begin
                nb = 0;
                for (int i = 0; i < nu; i++) if (st[i] == 1) nb++;
                if (nb == nu || (k == total && nb > 0))
                    for (int i = 0; i < nu; i++) if (st[i] == 1) ud[i] = 1'b1;
            end
            default: begin
                first = -1;
                for (int i = 0; i < nu; i++)
                    if (st[i] == 1 && (first < 0 || tile_k[i] < tile_k[first])) first = i;
                if (first >= 0 && $urandom_range(0, 1) == 1) ud[first] = 1'b1;
            end
        endcase
        if (noise && phase != 0 && $urandom_range(0, 3) == 0) start = 1'b1;
    endtask

    task automatic run_job(input int mode, input bit noise, input int rst_at, input int exp_done);
        int n;
        done_seen = 0;
        start = 1'b1; ud = '0;
        cycle();
        start = 1'b0; n = 0;
        while (phase != 0 && n < 500) begin
            drive(mode, noise);
            if (rst_at > 0 && n == rst_at) rst = 1'b1;
            cycle();
            rst = 1'b0;
            n++;
        end
        start = 1'b0; ud = '0;
        tests++;
        assert (phase == 0) else begin
            failed++;
            $error("FAIL job_timeout observed=%0d expected=0 cycle=%0d", phase, cyc);
        end
        chk("done_pulses", done_seen, exp_done);
        if (exp_done != 0) chk("final_jobs", 32'(o_jobs), total);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ud = '0; cyc = 0;
        set_cfg(0, 4, 2);
        cycle(); cycle();
        rst = 1'b0;
        cycle();

        // 4 units, 2x2: in-order, simultaneous, noisy random jobs
        run_job(3, 1'b0, 0, 1);
        cycle(); cycle();
        run_job(2, 1'b0, 0, 1);
        run_job(0, 1'b1, 0, 1);
        run_job(0, 1'b1, 0, 1);

        // Abort two cycles after the first dispatch, then restart cleanly
        run_job(0, 1'b0, 1, 0);
        cycle();
        run_job(3, 1'b0, 0, 1);

        // 2 units, 3x3: fixed latency, then random with noise
        set_cfg(1, 2, 3);
        run_job(1, 1'b0, 0, 1);
        run_job(0, 1'b1, 0, 1);

        // 4 units, single tile: surplus units stay untouched
        set_cfg(2, 4, 1);
        run_job(0, 1'b1, 0, 1);
        run_job(3, 1'b0, 0, 1);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
